// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: one shared slave, up to four masters.
// The grant is registered and held for the owner's entire cyc assertion.
module wb_arbiter #(
  parameter int MASTER_COUNT = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [MASTER_COUNT-1:0]            m_cyc_i,
  input  logic [MASTER_COUNT-1:0]            m_stb_i,
  input  logic [MASTER_COUNT-1:0]            m_we_i,
  input  logic [MASTER_COUNT*DATA_WIDTH-1:0] m_dat_i,
  input  logic [MASTER_COUNT*ADDR_WIDTH-1:0] m_adr_i,
  output logic [MASTER_COUNT-1:0]            m_ack_o,
  output logic [DATA_WIDTH-1:0]              m_dat_o,
  output logic                               s_cyc_o,
  output logic                               s_stb_o,
  output logic                               s_we_o,
  output logic [DATA_WIDTH-1:0]              s_dat_o,
  output logic [ADDR_WIDTH-1:0]              s_adr_o,
  input  logic                               s_ack_i,
  input  logic [DATA_WIDTH-1:0]              s_dat_i,
  output logic [MASTER_COUNT-1:0]            grant_o,
  output logic                               busy_o
);

  localparam int LW = $clog2(MASTER_COUNT);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t                  state;
  logic [MASTER_COUNT-1:0] grant;
  logic [LW-1:0]           last;
  logic [LW-1:0]           pick;
  logic                    found;
  logic                    owner_cyc;
  int                      j;

  assign owner_cyc = |(grant & m_cyc_i);

  // Round-robin scan: first requester after last, wrapping to last itself.
  always_comb begin
    found = 1'b0;
    pick  = last;
    j     = 0;
    for (int k = 1; k <= MASTER_COUNT; k++) begin
      j = int'(last) + k;
      if (j >= MASTER_COUNT) j = j - MASTER_COUNT;
      if (!found && m_cyc_i[j]) begin
        found = 1'b1;
        pick  = LW'(j);
      end
    end
  end

  // Arbitration FSM: grant on idle request or when the owner drops cyc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= LW'(MASTER_COUNT - 1);
    end else begin
      unique case (state)
        IDLE, OWN: begin
          if (state == IDLE || !owner_cyc) begin
            if (found) begin
              grant <= {{(MASTER_COUNT-1){1'b0}}, 1'b1} << pick;
              last  <= pick;
              state <= OWN;
            end else begin
              grant <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Owner's request signals to the slave; all zero with no grant.
  always_comb begin
    s_cyc_o = |(grant & m_cyc_i);
    s_stb_o = |(grant & m_stb_i);
    s_we_o  = |(grant & m_we_i);
    s_dat_o = '0;
    s_adr_o = '0;
    for (int i = 0; i < MASTER_COUNT; i++) begin
      if (grant[i]) begin
        s_dat_o = s_dat_o | m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        s_adr_o = s_adr_o | m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign m_ack_o = grant & {MASTER_COUNT{s_ack_i}};
  assign m_dat_o = s_dat_i;
  assign grant_o = grant;
  assign busy_o  = |grant;

endmodule
